// File: rtl/shift_reg_univ_pkg.sv
// shift_reg_univ_pkg: mode codes, FSM state encoding and shift-mode helper
package shift_reg_univ_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  function automatic logic is_shift(input logic [2:0] m);
    return m == MODE_SHL || m == MODE_SHR || m == MODE_ROTL || m == MODE_ROTR;
  endfunction
endpackage

// File: rtl/shift_reg_univ_op.sv
// shift_reg_univ_op: combinational next-value mux shared by direct and burst modes
module shift_reg_univ_op
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_nx
);
  // select the next register value for the requested operation
  always_comb begin
    case (op)
      MODE_SHL:  q_nx = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  q_nx = {sin_l, q[WIDTH-1:1]};
      MODE_LOAD: q_nx = d;
      MODE_ROTL: q_nx = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: q_nx = {q[0], q[WIDTH-1:1]};
      MODE_CLR:  q_nx = '0;
      default:   q_nx = q;
    endcase
  end
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with direct ops and counted shift bursts
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             so_l,
  output logic             so_r,
  output logic             busy,
  output logic             done
);
  state_t           state, state_nx;
  logic [2:0]       op_r, op_sel;
  logic [CNT_W-1:0] rem, rem_nx;
  logic [WIDTH-1:0] q_nx;
  logic             accept, last;
  // accept edge holds q; RUN replays the latched op; otherwise direct mode
  always_comb begin
    accept   = state == IDLE && start && is_shift(mode) && cnt != '0;
    last     = state == RUN && rem == CNT_W'(1);
    op_sel   = state == RUN ? op_r : (accept ? MODE_HOLD : mode);
    state_nx = accept ? RUN : (last ? IDLE : state);
    rem_nx   = accept ? cnt : (state == RUN ? rem - CNT_W'(1) : rem);
  end
  shift_reg_univ_op #(.WIDTH(WIDTH)) u_op (
    .op(op_sel), .q(q), .d(d), .sin_l(sin_l), .sin_r(sin_r), .q_nx(q_nx)
  );
  // data, control state and the done pulse registered on the final shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      state <= IDLE;
      op_r  <= MODE_HOLD;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      q     <= q_nx;
      state <= state_nx;
      op_r  <= accept ? mode : op_r;
      rem   <= rem_nx;
      done  <= last;
    end
  end
  assign busy = state == RUN;
  assign so_l = q[WIDTH-1];
  assign so_r = q[0];
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: table-driven scoreboard bench for shift_reg_univ (WIDTH=8)
module tb_shift_reg_univ;
  import shift_reg_univ_pkg::*;
  logic       clk = 1'b0, rst = 1'b0;
  logic [2:0] mode = MODE_HOLD;
  logic [7:0] d = '0;
  logic       sin_l = 1'b0, sin_r = 1'b0, start = 1'b0;
  logic [3:0] cnt = '0;
  logic [7:0] q;
  logic       so_l, so_r, busy, done;
  int         total = 0, passed = 0;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl, sr, st;
    logic [3:0] cnt;
    logic [7:0] eq;
    logic       eb, ed;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] eq;
    logic       eb, ed;
    string      name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  shift_reg_univ #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
    .start(start), .cnt(cnt), .q(q), .so_l(so_l), .so_r(so_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] m, input logic [7:0] dd, input logic sl, input logic sr,
                              input logic st, input logic [3:0] c, input logic [7:0] eq,
                              input logic eb, input logic ed, input string name);
    vec_t v;
    v.mode = m; v.d = dd; v.sl = sl; v.sr = sr; v.st = st; v.cnt = c;
    v.eq = eq; v.eb = eb; v.ed = ed; v.name = name;
    return v;
  endfunction

  task automatic step(input vec_t v);
    exp_t e;
    mode = v.mode; d = v.d; sin_l = v.sl; sin_r = v.sr; start = v.st; cnt = v.cnt;
    e.eq = v.eq; e.eb = v.eb; e.ed = v.ed; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".q"}, q, e.eq);
    chk({e.name, ".busy"}, {7'd0, busy}, {7'd0, e.eb});
    chk({e.name, ".done"}, {7'd0, done}, {7'd0, e.ed});
    chk({e.name, ".so"}, {6'd0, so_l, so_r}, {6'd0, e.eq[7], e.eq[0]});
  endtask

  task automatic async_rst(input string name);
    #1 rst = 1'b1;
    #1;
    chk({name, ".q"}, q, 8'h00);
    chk({name, ".busy"}, {7'd0, busy}, 8'h00);
    chk({name, ".done"}, {7'd0, done}, 8'h00);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.q", q, 8'h00);
    chk("reset.busy", {7'd0, busy}, 8'h00);
    chk("reset.done", {7'd0, done}, 8'h00);
    rst = 1'b0;

    tbl.push_back(mk(MODE_LOAD, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0, "load"));
    tbl.push_back(mk(MODE_SHL,  8'h00, 0, 1, 0, 0, 8'h4B, 0, 0, "shl"));
    tbl.push_back(mk(MODE_SHR,  8'h00, 0, 0, 0, 0, 8'h25, 0, 0, "shr"));
    tbl.push_back(mk(MODE_ROTL, 8'h00, 0, 0, 0, 0, 8'h4A, 0, 0, "rotl"));
    tbl.push_back(mk(MODE_ROTR, 8'h00, 0, 0, 0, 0, 8'h25, 0, 0, "rotr"));
    tbl.push_back(mk(MODE_CLR,  8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "clr"));
    tbl.push_back(mk(MODE_HOLD, 8'hFF, 1, 1, 0, 0, 8'h00, 0, 0, "hold"));
    tbl.push_back(mk(MODE_LOAD, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0, "b_load"));
    tbl.push_back(mk(MODE_ROTL, 8'h00, 0, 0, 1, 3, 8'h81, 1, 0, "b_accept"));
    tbl.push_back(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h03, 1, 0, "b_s1"));
    tbl.push_back(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h06, 1, 0, "b_s2"));
    tbl.push_back(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h0C, 0, 1, "b_s3"));
    tbl.push_back(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h0C, 0, 0, "b_after"));
    foreach (tbl[i]) step(tbl[i]);

    step(mk(MODE_LOAD, 8'h5A, 0, 0, 0, 0, 8'h5A, 0, 0, "ar_load"));
    async_rst("ar");
    step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "ar_hold"));

    step(mk(MODE_LOAD, 8'hF0, 0, 0, 0, 0, 8'hF0, 0, 0, "bi_load"));
    step(mk(MODE_SHR,  8'h00, 0, 0, 1, 4, 8'hF0, 1, 0, "bi_accept"));
    step(mk(MODE_LOAD, 8'hFF, 0, 0, 1, 4, 8'h78, 1, 0, "bi_s1"));
    step(mk(MODE_LOAD, 8'hFF, 1, 0, 1, 4, 8'hBC, 1, 0, "bi_s2"));
    step(mk(MODE_CLR,  8'hFF, 0, 0, 1, 4, 8'h5E, 1, 0, "bi_s3"));
    step(mk(MODE_LOAD, 8'hFF, 0, 0, 1, 4, 8'h2F, 0, 1, "bi_s4"));
    step(mk(MODE_SHR,  8'h00, 0, 0, 1, 1, 8'h2F, 1, 0, "bi_b2b_accept"));
    step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h17, 0, 1, "bi_b2b_s1"));

    step(mk(MODE_LOAD, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0, "dg_load"));
    step(mk(MODE_SHL,  8'h00, 0, 0, 1, 0, 8'h02, 0, 0, "dg_cnt0"));
    step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h02, 0, 0, "dg_quiet"));
    step(mk(MODE_LOAD, 8'h33, 0, 0, 1, 3, 8'h33, 0, 0, "dg_noshift"));

    step(mk(MODE_LOAD, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0, "rm_load"));
    step(mk(MODE_ROTR, 8'h00, 0, 0, 1, 5, 8'h01, 1, 0, "rm_accept"));
    step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h80, 1, 0, "rm_s1"));
    step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h40, 1, 0, "rm_s2"));
    async_rst("rm");
    for (int i = 0; i < 4; i++) step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, "rm_nodone"));
    step(mk(MODE_LOAD, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0, "rf_load"));
    step(mk(MODE_ROTL, 8'h00, 0, 0, 1, 3, 8'h81, 1, 0, "rf_accept"));
    step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h03, 1, 0, "rf_s1"));
    step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h06, 1, 0, "rf_s2"));
    step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h0C, 0, 1, "rf_s3"));

    step(mk(MODE_LOAD, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0, "r8_load"));
    step(mk(MODE_ROTL, 8'h00, 0, 0, 1, 8, 8'h81, 1, 0, "r8_accept"));
    for (int i = 1; i < 8; i++) begin
      logic [7:0] v;
      v = 8'h81;
      v = (v << i) | (v >> (8 - i));
      step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, v, 1, 0, "r8_s"));
    end
    step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h81, 0, 1, "r8_last"));

    step(mk(MODE_LOAD, 8'hFF, 0, 0, 0, 0, 8'hFF, 0, 0, "sh10_load"));
    step(mk(MODE_SHL,  8'h00, 0, 0, 1, 10, 8'hFF, 1, 0, "sh10_accept"));
    for (int i = 1; i < 10; i++) begin
      logic [7:0] v;
      v = (i >= 8) ? 8'h00 : (8'hFF << i);
      step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, v, 1, 0, "sh10_s"));
    end
    step(mk(MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, "sh10_last"));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
